// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_t;

  localparam int unsigned UART_FULL_BIT  = 21812;
  localparam int unsigned UART_HALF_BIT  = 10906;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = 16;
  localparam int unsigned UART_IDX_W     = 4;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while running, held at 0 otherwise.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = UART_FULL_BIT
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_run,
  output logic o_bit_end
);

  localparam logic [UART_CNT_W-1:0] LAST_COUNT = UART_CNT_W'(BIT_CYCLES - 1);

  logic [UART_CNT_W-1:0] r_count;

  assign o_bit_end = (r_count == LAST_COUNT);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (!i_run || o_bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + UART_CNT_W'(1);
    end
  end

  a_count_in_range : assert property (@(posedge clk) disable iff (!i_reset_n)
    r_count <= LAST_COUNT);

endmodule : uart_bit_timer

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer with a one-entry holding register for gapless back-to-back frames.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = UART_FULL_BIT
) (
  input  logic                      clk,
  input  logic                      i_reset_n,
  input  logic [0:UART_DATA_BITS-1] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_t                 r_state;
  uart_state_t                 state_next;
  logic [0:UART_DATA_BITS-1]   r_hold;
  logic                        r_hold_full;
  logic [0:UART_DATA_BITS-1]   r_shift;
  logic [UART_IDX_W-1:0]       r_bit_idx;
  logic [UART_IDX_W-1:0]       bit_idx_next;
  logic                        r_tx;
  logic                        r_busy;
  logic                        bit_end;
  logic                        accept_c;
  logic                        load_c;
  logic                        done_c;
  logic                        tx_next;

  uart_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_run     (r_state != IDLE),
    .o_bit_end (bit_end)
  );

  assign accept_c = i_valid && !r_hold_full;
  assign o_ready  = !r_hold_full;
  assign o_tx     = r_tx;
  assign o_busy   = r_busy;
  assign o_done   = done_c;

  // Shifter state register
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= state_next;
    end
  end

  // Next-state, shifter load and line value for the coming cycle
  always_comb begin
    state_next   = r_state;
    bit_idx_next = r_bit_idx;
    load_c       = 1'b0;
    done_c       = 1'b0;
    tx_next      = 1'b1;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          state_next   = START_BIT;
          load_c       = 1'b1;
          bit_idx_next = '0;
        end
      end
      START_BIT: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next   = DATA_BITS;
          bit_idx_next = '0;
        end
      end
      DATA_BITS: begin
        tx_next = r_shift[r_bit_idx[2:0]];
        if (bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            state_next = STOP_BIT;
          end else begin
            bit_idx_next = r_bit_idx + UART_IDX_W'(1);
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          done_c = 1'b1;
          if (r_hold_full) begin
            state_next   = START_BIT;
            load_c       = 1'b1;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Holding register, shift register, bit index and registered line outputs
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (accept_c) begin
        r_hold      <= i_data;
        r_hold_full <= 1'b1;
      end else if (load_c) begin
        r_hold_full <= 1'b0;
      end
      if (load_c) begin
        r_shift <= r_hold;
      end
      r_bit_idx <= bit_idx_next;
      r_tx      <= tx_next;
      r_busy    <= (state_next != IDLE);
    end
  end

  // A load only happens with the holding register full, so no handshake can coincide
  a_no_accept_on_load : assert property (@(posedge clk) disable iff (!i_reset_n)
    !(accept_c && load_c));

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with BIT_CYCLES=4 and hand-derived line waveforms.
module tb_uart_transmitter;

  localparam int unsigned BC = 4;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic [0:7] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .BIT_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level c cycles after the start bit begins: start, data[0..7], stop
  function automatic logic exp_bit(input logic [0:7] b, input int c);
    int k;
    k = c / int'(BC);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Checks the 40 cycles of one frame, starting with the edge where o_tx falls
  task automatic check_frame(input logic [0:7] b, input string name, input int ready_low,
                             input int chg_at, input logic chg_valid, input logic [0:7] chg_data);
    for (int c = 0; c < 10 * int'(BC); c++) begin
      @(posedge clk); #1;
      check($sformatf("%s tx c%0d", name, c), 32'(o_tx), 32'(exp_bit(b, c)));
      check($sformatf("%s done c%0d", name, c), 32'(o_done), 32'(c == 10 * int'(BC) - 2));
      check($sformatf("%s ready c%0d", name, c), 32'(o_ready), 32'(c >= ready_low));
      if (c == chg_at) begin
        i_valid = chg_valid;
        i_data  = chg_data;
      end
    end
  endtask

  initial begin
    logic [0:7] b_single;
    int         bad;
    b_single  = 8'b1011_0010;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst tx", 32'(o_tx), 32'd1);
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    i_reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle tx %0d", i), 32'(o_tx), 32'd1);
    end

    // Single byte
    i_data  = b_single;
    i_valid = 1'b1;
    check("single ready pre", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    check("single ready N", 32'(o_ready), 32'd0);
    check("single busy N", 32'(o_busy), 32'd0);
    check("single tx N", 32'(o_tx), 32'd1);
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("single ready N1", 32'(o_ready), 32'd1);
    check("single busy N1", 32'(o_busy), 32'd1);
    check("single tx N1", 32'(o_tx), 32'd1);
    check_frame(b_single, "single", 0, -1, 1'b0, 8'h00);
    check("single busy end", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check("single tx after", 32'(o_tx), 32'd1);
    check("single busy after", 32'(o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back 55 then A3 with i_valid held high
    i_data  = 8'h55;
    i_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b ready N", 32'(o_ready), 32'd0);
    i_data = 8'hA3;
    @(posedge clk); #1;
    check("b2b ready N1", 32'(o_ready), 32'd1);
    check_frame(8'h55, "b2b0", 39, 0, 1'b0, 8'h00);
    check("b2b busy gap", 32'(o_busy), 32'd1);
    check_frame(8'hA3, "b2b1", 0, -1, 1'b0, 8'h00);
    check("b2b busy end", 32'(o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: third byte waits until the first stop bit ends
    i_data  = 8'hC4;
    i_valid = 1'b1;
    @(posedge clk); #1;
    check("bp ready N", 32'(o_ready), 32'd0);
    i_data = 8'h3E;
    @(posedge clk); #1;
    check("bp ready N1", 32'(o_ready), 32'd1);
    check_frame(8'hC4, "bp0", 39, 0, 1'b1, 8'h81);
    check_frame(8'h3E, "bp1", 39, 0, 1'b0, 8'h00);
    check_frame(8'h81, "bp2", 0, -1, 1'b0, 8'h00);
    check("bp busy end", 32'(o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame during data bit 3, with a second byte held
    i_data  = 8'h00;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_data = 8'h0F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid ready held", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("mid tx bit3", 32'(o_tx), 32'd0);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("mid rst tx", 32'(o_tx), 32'd1);
    check("mid rst ready", 32'(o_ready), 32'd1);
    check("mid rst busy", 32'(o_busy), 32'd0);
    check("mid rst done", 32'(o_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) bad++;
    end
    check("mid no frame after", 32'(bad), 32'd0);

    // Loopback-style bytes sent back-to-back
    i_data  = 8'h00;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_data = 8'hFF;
    @(posedge clk); #1;
    check_frame(8'h00, "lb0", 39, 0, 1'b1, 8'h5A);
    check_frame(8'hFF, "lb1", 39, 0, 1'b0, 8'h00);
    check_frame(8'h5A, "lb2", 0, -1, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("lb idle tx", 32'(o_tx), 32'd1);
    check("lb idle busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_transmitter
